// File: rtl/div_result_bcd_pkg.sv
// -----------------------------------------------------------------------------
// div_result_bcd_pkg
// Shared definitions for the divider result BCD stage:
//   - state_t    : conversion FSM encoding (IDLE/CONV_Q/CONV_R/HOLD)
//   - BCD_BLANK  : display blank code used for suppressed leading zeros
//   - DEF_*      : default widths (5-bit quotient, 4-bit remainder, 2+2 digits)
//   - add3()     : double-dabble digit correction (d >= 5 ? d + 3 : d)
// -----------------------------------------------------------------------------
package div_result_bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV_Q = 2'd1,
    S_CONV_R = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam int DEF_QW = 5;
  localparam int DEF_RW = 4;
  localparam int DEF_QD = 2;
  localparam int DEF_RD = 2;

  // A digit >= 5 would become >= 10 after the following left shift, so it is
  // pre-corrected by 3. Digits never exceed 9, so the result fits in 4 bits.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/div_result_bcd_if.sv
// -----------------------------------------------------------------------------
// div_result_bcd_if
// Bundles the divider-facing capture inputs and the readout-facing result
// handshake of div_result_bcd.
//   done_in : divider Done level; a rising edge means quo/rem are ready
//   quo     : quotient  [QW-1:0], stable while done_in is high
//   rem     : remainder [RW-1:0], stable while done_in is high
//   ack     : consumer accepts the result when valid & ack at a clock edge
//   valid   : q_bcd/r_bcd hold a complete result
//   q_bcd   : packed BCD quotient  [4*QD-1:0], MS digit high
//   r_bcd   : packed BCD remainder [4*RD-1:0], MS digit high
//   busy    : conversion in progress
//   ovr     : sticky, a Done edge arrived while the stage was not idle
//   state   : conversion FSM state (debug visibility)
// Modports: master = divider + consumer side, slave = the BCD stage.
// -----------------------------------------------------------------------------
interface div_result_bcd_if #(
  parameter int QW = div_result_bcd_pkg::DEF_QW,
  parameter int RW = div_result_bcd_pkg::DEF_RW,
  parameter int QD = div_result_bcd_pkg::DEF_QD,
  parameter int RD = div_result_bcd_pkg::DEF_RD
);

  logic                        done_in;
  logic [QW-1:0]               quo;
  logic [RW-1:0]               rem;
  logic                        ack;
  logic                        valid;
  logic [4*QD-1:0]             q_bcd;
  logic [4*RD-1:0]             r_bcd;
  logic                        busy;
  logic                        ovr;
  div_result_bcd_pkg::state_t  state;

  modport master (
    output done_in, quo, rem, ack,
    input  valid, q_bcd, r_bcd, busy, ovr, state
  );

  modport slave (
    input  done_in, quo, rem, ack,
    output valid, q_bcd, r_bcd, busy, ovr, state
  );

endinterface

// File: rtl/div_result_bcd_add3.sv
// -----------------------------------------------------------------------------
// div_result_bcd_add3
// Combinational double-dabble correction for one BCD digit.
//   d_in  : accumulator digit (0..9)
//   d_out : d_in >= 5 ? d_in + 3 : d_in
// -----------------------------------------------------------------------------
module div_result_bcd_add3
  import div_result_bcd_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  assign d_out = add3(d_in);

endmodule

// File: rtl/div_result_bcd.sv
// -----------------------------------------------------------------------------
// div_result_bcd
// Downstream stage of the 5-bit restoring divider. Captures quotient and
// remainder on the rising edge of the divider's Done level, converts each to
// packed BCD with a sequential shift-add-3 engine (one bit per clock, quotient
// first, then remainder), and holds the result for the readout stage.
//
// Ports:
//   clk   : rising-edge clock, shared with the divider
//   rst_n : synchronous active-low reset; wins over every other event
//   bus   : div_result_bcd_if.slave (done_in/quo/rem/ack in;
//           valid/q_bcd/r_bcd/busy/ovr/state out)
//
// Handshake: valid is high exactly while the FSM is in HOLD; a result is
// accepted at a clock edge where valid & ack are both high, and the stage is
// idle from the next cycle. ack while valid is low has no effect. A Done rise
// is only accepted in IDLE; any other rise (including one on the accepting
// edge) sets the sticky ovr flag and is dropped. The next accepted capture
// clears ovr.
//
// Timing: with the Done rise sampled at edge 1, valid is first high after
// edge QW+RW+1 (10 with default widths).
//
// Build option: define DIV_BCD_ZERO_BLANK_EN to output leading zero digits of
// q_bcd/r_bcd as the blank code 4'hF (the least significant digit is never
// blanked). Without it all digits are output as computed.
// -----------------------------------------------------------------------------
module div_result_bcd
  import div_result_bcd_pkg::*;
#(
  parameter int QW = DEF_QW,
  parameter int RW = DEF_RW,
  parameter int QD = DEF_QD,
  parameter int RD = DEF_RD
) (
  input  logic           clk,
  input  logic           rst_n,
  div_result_bcd_if.slave bus
);

  // One accumulator sized for the wider of the two conversions is reused.
  localparam int ND = (QD > RD) ? QD : RD;
  localparam int AW = 4 * ND;
  localparam int SW = (QW > RW) ? QW : RW;
  localparam int CW = (SW > 1) ? $clog2(SW) : 1;

  state_t          state;
  state_t          state_nxt;
  logic            done_d;
  logic            rise;
  logic [QW-1:0]   q_sr;
  logic [RW-1:0]   r_sr;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   adj;
  logic [AW-1:0]   acc_next;
  logic            bit_in;
  logic [4*QD-1:0] q_tmp;
  logic [4*QD-1:0] q_fmt;
  logic [4*RD-1:0] r_fmt;
  logic [4*QD-1:0] q_bcd_r;
  logic [4*RD-1:0] r_bcd_r;
  logic            ovr_r;
  logic            unused_bits;

  assign rise = bus.done_in & ~done_d;

  // ---------------------------------------------------------------------------
  // Double-dabble datapath: correct every digit, then shift in the next bit.
  // The corrected MS bit is shifted out; it is always 0 for legal widths.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < ND; i++) begin : g_dig
    div_result_bcd_add3 u_add3 (
      .d_in  (acc[4*i +: 4]),
      .d_out (adj[4*i +: 4])
    );
  end

  assign bit_in      = (state == S_CONV_Q) ? q_sr[QW-1] : r_sr[RW-1];
  assign acc_next    = {adj[AW-2:0], bit_in};
  assign unused_bits = ^{adj[AW-1], acc_next};

  // ---------------------------------------------------------------------------
  // Output digit formatting, applied once when the result is registered so the
  // reset value of q_bcd/r_bcd stays all-zero in both builds.
  // ---------------------------------------------------------------------------
  always_comb begin
    q_fmt = q_tmp;
`ifdef DIV_BCD_ZERO_BLANK_EN
    begin : q_blank
      logic q_lead;
      q_lead = 1'b1;
      for (int i = QD - 1; i > 0; i--) begin
        if (q_lead && (q_tmp[4*i +: 4] == 4'd0)) begin
          q_fmt[4*i +: 4] = BCD_BLANK;
        end else begin
          q_lead = 1'b0;
        end
      end
    end
`endif
  end

  always_comb begin
    r_fmt = acc_next[4*RD-1:0];
`ifdef DIV_BCD_ZERO_BLANK_EN
    begin : r_blank
      logic r_lead;
      r_lead = 1'b1;
      for (int i = RD - 1; i > 0; i--) begin
        if (r_lead && (acc_next[4*i +: 4] == 4'd0)) begin
          r_fmt[4*i +: 4] = BCD_BLANK;
        end else begin
          r_lead = 1'b0;
        end
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (rise)        state_nxt = S_CONV_Q;
      S_CONV_Q: if (cnt == '0)   state_nxt = S_CONV_R;
      S_CONV_R: if (cnt == '0)   state_nxt = S_HOLD;
      S_HOLD:   if (bus.ack)     state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.valid = (state == S_HOLD);
    bus.busy  = (state == S_CONV_Q) || (state == S_CONV_R);
    bus.state = state;
  end

  assign bus.q_bcd = q_bcd_r;
  assign bus.r_bcd = r_bcd_r;
  assign bus.ovr   = ovr_r;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_d  <= 1'b0;
      q_sr    <= '0;
      r_sr    <= '0;
      cnt     <= '0;
      acc     <= '0;
      q_tmp   <= '0;
      q_bcd_r <= '0;
      r_bcd_r <= '0;
      ovr_r   <= 1'b0;
    end else begin
      done_d <= bus.done_in;

      case (state)
        S_IDLE: begin
          if (rise) begin
            q_sr  <= bus.quo;
            r_sr  <= bus.rem;
            acc   <= '0;
            ovr_r <= 1'b0;
            cnt   <= CW'(QW - 1);
          end
        end
        S_CONV_Q: begin
          acc  <= acc_next;
          q_sr <= q_sr << 1;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            // Park the quotient digits so the accumulator can be reused.
            q_tmp <= acc_next[4*QD-1:0];
            acc   <= '0;
            cnt   <= CW'(RW - 1);
          end
        end
        S_CONV_R: begin
          acc  <= acc_next;
          r_sr <= r_sr << 1;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            // Outputs change only here, so a previous result stays visible
            // for the whole conversion.
            q_bcd_r <= q_fmt;
            r_bcd_r <= r_fmt;
          end
        end
        default: ;
      endcase

      // A rise outside IDLE is dropped; the in-flight result is untouched.
      if (rise && (state != S_IDLE)) begin
        ovr_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// -----------------------------------------------------------------------------
// tb_div_result_bcd
// Self-checking bench for div_result_bcd: directed scenarios with literal
// expectations, then randomized Done/ACK/reset traffic. A transaction-level
// model (countdown latency, decimal digits via / and %) predicts outputs and
// a per-cycle compare process checks the DUT against it.
// -----------------------------------------------------------------------------
module tb_div_result_bcd;

  localparam int QW = 5;
  localparam int RW = 4;
  localparam int QD = 2;
  localparam int RD = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_result_bcd_if #(.QW(QW), .RW(RW), .QD(QD), .RD(RD)) bus ();

  div_result_bcd #(.QW(QW), .RW(RW), .QD(QD), .RD(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [7:0] disp(input logic [7:0] b);
    logic [7:0] r;
    r = b;
`ifdef DIV_BCD_ZERO_BLANK_EN
    if (b[7:4] == 4'd0) r[7:4] = 4'hF;
`endif
    return r;
  endfunction

  logic [15:0] exp_q[$];
  bit          m_done_d;
  bit          m_valid;
  bit          m_ovr;
  int          m_busy;
  logic [7:0]  m_q;
  logic [7:0]  m_r;
  bit          m_rise;
  bit          chk_en = 1'b0;

  // Inputs are driven 1ns after each rising edge, so they are stable here.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_done_d = 1'b0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      m_busy   = 0;
      m_q      = 8'h00;
      m_r      = 8'h00;
      exp_q.delete();
      chk_en   = 1'b1;
    end else begin
      m_rise = bus.done_in && !m_done_d;
      if (m_busy > 0) begin
        if (m_rise) m_ovr = 1'b1;
        m_busy--;
        if (m_busy == 0) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
          end else begin
            {m_q, m_r} = exp_q.pop_front();
          end
          m_valid = 1'b1;
        end
      end else if (m_valid) begin
        if (m_rise) m_ovr = 1'b1;
        if (bus.ack) m_valid = 1'b0;
      end else if (m_rise) begin
        exp_q.push_back({disp(to_bcd(int'(bus.quo))), disp(to_bcd(int'(bus.rem)))});
        m_busy = QW + RW;
        m_ovr  = 1'b0;
      end
      m_done_d = bus.done_in;
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] exp_state;
      exp_state = m_valid ? 2'd3 : (m_busy > RW) ? 2'd1 : (m_busy > 0) ? 2'd2 : 2'd0;
      chk("cyc_valid", 32'(bus.valid), 32'(m_valid));
      chk("cyc_busy",  32'(bus.busy),  32'(m_busy > 0));
      chk("cyc_ovr",   32'(bus.ovr),   32'(m_ovr));
      chk("cyc_q_bcd", 32'(bus.q_bcd), 32'(m_q));
      chk("cyc_r_bcd", 32'(bus.r_bcd), 32'(m_r));
      chk("cyc_state", 32'(bus.state), 32'(exp_state));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_conv(input int q, input int r, input bit hold, output int lat);
    bus.quo     = 5'(q);
    bus.rem     = 4'(r);
    bus.done_in = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (!hold) bus.done_in = 1'b0;
    end while (!bus.valid && lat < 40);
  endtask

  task automatic ack_it();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("valid_after_ack", 32'(bus.valid), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int n;
    bus.done_in = 1'b0;
    bus.quo     = '0;
    bus.rem     = '0;
    bus.ack     = 1'b0;
    rst_n       = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_ovr",   32'(bus.ovr),   32'd0);
    chk("rst_q",     32'(bus.q_bcd), 32'h00);
    chk("rst_r",     32'(bus.r_bcd), 32'h00);
    rst_n = 1'b1;

    // Reset in the middle of the quotient conversion.
    bus.quo = 5'd10; bus.rem = 4'd5; bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    tick();
    tick();
    chk("t1_busy_before_rst", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t1_valid", 32'(bus.valid), 32'd0);
    chk("t1_busy",  32'(bus.busy),  32'd0);
    chk("t1_q",     32'(bus.q_bcd), 32'h00);
    chk("t1_r",     32'(bus.r_bcd), 32'h00);
    chk("t1_state", 32'(bus.state), 32'd0);

    // 135 / 13 = 10 r 5.
    run_conv(10, 5, 1'b0, lat);
    chk("t2_latency", 32'(lat), 32'd10);
    chk("t2_q", 32'(bus.q_bcd), 32'h10);
`ifdef DIV_BCD_ZERO_BLANK_EN
    chk("t2_r", 32'(bus.r_bcd), 32'hF5);
`else
    chk("t2_r", 32'(bus.r_bcd), 32'h05);
`endif
    chk("t2_ovr", 32'(bus.ovr), 32'd0);
    ack_it();

    // Extremes.
    run_conv(31, 15, 1'b0, lat);
    chk("t3_q_max", 32'(bus.q_bcd), 32'h31);
    chk("t3_r_max", 32'(bus.r_bcd), 32'h15);
    ack_it();
    run_conv(0, 0, 1'b0, lat);
`ifdef DIV_BCD_ZERO_BLANK_EN
    chk("t3_q_zero", 32'(bus.q_bcd), 32'hF0);
    chk("t3_r_zero", 32'(bus.r_bcd), 32'hF0);
`else
    chk("t3_q_zero", 32'(bus.q_bcd), 32'h00);
    chk("t3_r_zero", 32'(bus.r_bcd), 32'h00);
`endif
    ack_it();

    // Second rise during conversion is an overrun and is dropped.
    bus.quo = 5'd10; bus.rem = 4'd5; bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    tick();
    tick();
    bus.quo = 5'd1; bus.rem = 4'd2; bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    n = 0;
    while (!bus.valid && n < 40) begin
      tick();
      n++;
    end
    chk("t4_valid", 32'(bus.valid), 32'd1);
    chk("t4_ovr",   32'(bus.ovr),   32'd1);
    chk("t4_q",     32'(bus.q_bcd), 32'h10);
`ifdef DIV_BCD_ZERO_BLANK_EN
    chk("t4_r", 32'(bus.r_bcd), 32'hF5);
`else
    chk("t4_r", 32'(bus.r_bcd), 32'h05);
`endif
    ack_it();

    // Back-to-back capture after ACK; clears the overrun flag.
    run_conv(1, 2, 1'b0, lat);
`ifdef DIV_BCD_ZERO_BLANK_EN
    chk("t6_q", 32'(bus.q_bcd), 32'hF1);
    chk("t6_r", 32'(bus.r_bcd), 32'hF2);
`else
    chk("t6_q", 32'(bus.q_bcd), 32'h01);
    chk("t6_r", 32'(bus.r_bcd), 32'h02);
`endif
    chk("t6_ovr", 32'(bus.ovr), 32'd0);
    ack_it();

    // Done held high throughout; result held 20 cycles without ACK.
    run_conv(27, 9, 1'b1, lat);
    chk("t5_latency", 32'(lat), 32'd10);
    repeat (20) tick();
    chk("t5_valid_held", 32'(bus.valid), 32'd1);
    chk("t5_q_held", 32'(bus.q_bcd), 32'h27);
`ifdef DIV_BCD_ZERO_BLANK_EN
    chk("t5_r_held", 32'(bus.r_bcd), 32'hF9);
`else
    chk("t5_r_held", 32'(bus.r_bcd), 32'h09);
`endif
    ack_it();
    repeat (3) tick();
    chk("t5_no_recapture_busy",  32'(bus.busy),  32'd0);
    chk("t5_no_recapture_state", 32'(bus.state), 32'd0);
    bus.done_in = 1'b0;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (bus.done_in) begin
        if ($urandom_range(0, 3) == 0) bus.done_in = 1'b0;
      end else begin
        bus.quo = 5'($urandom);
        bus.rem = 4'($urandom);
        if ($urandom_range(0, 5) == 0) bus.done_in = 1'b1;
      end
      bus.ack = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst_n = 1'b1;
    bus.ack = 1'b0;
    bus.done_in = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
